multicycle_control_unit: RTL and testbench

- Main FSM that sequences the shared multi-cycle RV32I datapath: one memory port, one ALU, the result/data/a/b buffers, and pc/pc_buf/instruction registers.
- Each state drives the mux selects, the write enables and alu_op, using decoded instruction fields and alu_zero.
- Adds a mem_ready stall handshake and halt/illegal status for the top level.

---
 rtl/multicycle_control_unit_pkg.sv | 85 ++++++++
 rtl/multicycle_control_unit_alu_op_decoder.sv | 45 ++++
 rtl/multicycle_control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// opcodes, ALU ops, datapath mux selects and FSM states.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_PCBUF = 2'b01,
        SRC_A_ABUF  = 2'b10,
        SRC_A_ZERO  = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_BBUF = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10,
        SRC_B_ZERO = 2'b11
    } src_b_e;

    typedef enum logic [1:0] {
        RES_BUF  = 2'b00,
        RES_DATA = 2'b01,
        RES_ALU  = 2'b10
    } res_src_e;

    typedef enum logic [1:0] {
        CLS_ADD    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_R      = 2'b10,
        CLS_I      = 2'b11
    } alu_class_e;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_PC   = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_HALT      = 4'd15
    } state_e;

    // EQ/NE compare via SUB zero flag; LT/GE and LTU/GEU via SLT(U)
    // result, whose zero flag is inverted when the condition holds.
    function automatic logic branch_taken(
        input logic [2:0] f3,
        input logic       zero
    );
        return zero ^ (f3[0] ^ f3[2]);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// Combinational ALU operation select from funct fields
// and the operation class chosen by the sequencing FSM.
module multicycle_control_unit_alu_op_decoder
    import multicycle_control_unit_pkg::*;
(
    input  alu_class_e   alu_class_i,
    input  logic [2:0]   funct3_i,
    input  logic         funct7_5_i,
    output alu_op_e      alu_op_o
);

    logic alt;

    // Immediate forms only use funct7[5] to pick SRAI over SRLI.
    assign alt = funct7_5_i &&
                 ((alu_class_i == CLS_R) || (funct3_i == 3'b101));

    // Map class and funct fields onto the ALU operation.
    always_comb begin
        alu_op_o = ALU_ADD;
        unique case (alu_class_i)
            CLS_ADD: alu_op_o = ALU_ADD;
            CLS_BRANCH: begin
                case (funct3_i[2:1])
                    2'b10:   alu_op_o = ALU_SLT;
                    2'b11:   alu_op_o = ALU_SLTU;
                    default: alu_op_o = ALU_SUB;
                endcase
            end
            CLS_R, CLS_I: begin
                case (funct3_i)
                    3'b000:  alu_op_o = alt ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_o = ALU_SLL;
                    3'b010:  alu_op_o = ALU_SLT;
                    3'b011:  alu_op_o = ALU_SLTU;
                    3'b100:  alu_op_o = ALU_XOR;
                    3'b101:  alu_op_o = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM for the shared multi-cycle RV32I datapath.
// State is registered; all datapath controls decode from it.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter bit HALT_ON_SYSTEM  = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_addr_src,
    output logic       mem_we,
    output logic       instr_we,
    output logic       pc_we,
    output logic       rf_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] alu_op,
    output logic       retire,
    output logic       halted,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    src_a_e     src_a;
    src_b_e     src_b;
    res_src_e   res_src;
    alu_class_e alu_class;
    alu_op_e    alu_op_w;
    logic       bad_op;
    logic       unused_funct7;

    // Only funct7[5] distinguishes SUB/SRA; other bits are don't-care.
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    multicycle_control_unit_alu_op_decoder u_alu_dec (
        .alu_class_i (alu_class),
        .funct3_i    (funct3),
        .funct7_5_i  (funct7[5]),
        .alu_op_o    (alu_op_w)
    );

    // Opcodes with no sequence, plus branches with reserved funct3 01x.
    always_comb begin
        bad_op = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_OP, OP_IMM,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
            OP_FENCE, OP_SYSTEM: bad_op = 1'b0;
            OP_BRANCH: bad_op = (funct3[2:1] == 2'b01);
            default:   bad_op = 1'b1;
        endcase
    end

    // Next-state and control decode for the current state.
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        mem_addr_src = 1'b0;
        mem_we       = 1'b0;
        instr_we     = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;
        src_a        = SRC_A_PC;
        src_b        = SRC_B_BBUF;
        res_src      = RES_BUF;
        alu_class    = CLS_ADD;
        unique case (state_q)
            S_FETCH: begin
                src_b   = SRC_B_FOUR;
                res_src = RES_ALU;
                if (mem_ready) begin
                    instr_we = 1'b1;
                    pc_we    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = SRC_A_PCBUF;
                src_b = SRC_B_IMM;
                if (bad_op) begin
                    if (HALT_ON_ILLEGAL) begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                        OP_OP:     state_d = S_EXEC_R;
                        OP_IMM:    state_d = S_EXEC_I;
                        OP_BRANCH: state_d = S_BRANCH;
                        OP_JAL:    state_d = S_JAL;
                        OP_JALR:   state_d = S_JALR;
                        OP_LUI:    state_d = S_LUI;
                        OP_AUIPC:  state_d = S_AUIPC;
                        OP_SYSTEM: begin
                            if (HALT_ON_SYSTEM) begin
                                state_d = S_HALT;
                            end else begin
                                retire  = 1'b1;
                                state_d = S_FETCH;
                            end
                        end
                        default: begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end
            S_MEM_ADDR: begin
                src_a   = SRC_A_ABUF;
                src_b   = SRC_B_IMM;
                state_d = (opcode == OP_LOAD) ? S_MEM_READ
                                              : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_addr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                res_src = RES_DATA;
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_addr_src = 1'b1;
                mem_we       = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                src_a     = SRC_A_ABUF;
                alu_class = CLS_R;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a     = SRC_A_ABUF;
                src_b     = SRC_B_IMM;
                alu_class = CLS_I;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                src_a   = SRC_A_ZERO;
                src_b   = SRC_B_IMM;
                state_d = S_ALU_WB;
            end
            S_AUIPC: begin
                src_a   = SRC_A_PCBUF;
                src_b   = SRC_B_IMM;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                src_a     = SRC_A_ABUF;
                alu_class = CLS_BRANCH;
                pc_we     = branch_taken(funct3, alu_zero);
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                pc_we   = 1'b1;
                src_a   = SRC_A_PCBUF;
                src_b   = SRC_B_FOUR;
                state_d = S_ALU_WB;
            end
            S_JALR: begin
                src_a   = SRC_A_ABUF;
                src_b   = SRC_B_IMM;
                state_d = S_JALR_PC;
            end
            S_JALR_PC: begin
                pc_we   = 1'b1;
                src_a   = SRC_A_PCBUF;
                src_b   = SRC_B_FOUR;
                state_d = S_ALU_WB;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
        if (rst) begin
            mem_we   = 1'b0;
            instr_we = 1'b0;
            pc_we    = 1'b0;
            rf_we    = 1'b0;
            retire   = 1'b0;
        end
    end

    // State and sticky illegal flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_src_a  = src_a;
    assign alu_src_b  = src_b;
    assign result_src = res_src;
    assign alu_op     = alu_op_w;
    assign halted     = (state_q == S_HALT);
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus pushes
// expected per-instruction behaviour, a monitor checks at retire.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_addr_src, mem_we, instr_we, pc_we, rf_we;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_op;
    logic       retire, halted, illegal;

    multicycle_control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .mem_addr_src (mem_addr_src),
        .mem_we       (mem_we),
        .instr_we     (instr_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .result_src   (result_src),
        .alu_op       (alu_op),
        .retire       (retire),
        .halted       (halted),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        int          ni;
        int          np;
        int          nr;
        int          nm;
        int          i0;
        logic [13:0] v0;
        int          i1;
        logic [13:0] v1;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [1:0] b;
        logic [3:0] aop;
    } alu_vec_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic        mon_en = 1'b0;
    int          m_cyc, m_i, m_p, m_r, m_m;
    logic [13:0] hist[64];

    function automatic logic [13:0] sn(
        input logic mas, input logic mwe,
        input logic pcw, input logic rfw,
        input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] r, input logic [3:0] op
    );
        return {mas, mwe, pcw, rfw, a, b, r, op};
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: accumulates per-instruction activity, checks at retire.
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            m_cyc = 0; m_i = 0; m_p = 0; m_r = 0; m_m = 0;
        end else begin
            if (m_cyc < 64)
                hist[m_cyc] = {mem_addr_src, mem_we, pc_we, rf_we,
                               alu_src_a, alu_src_b, result_src,
                               alu_op};
            m_cyc++;
            m_i += int'(instr_we);
            m_p += int'(pc_we);
            m_r += int'(rf_we);
            m_m += int'(mem_we);
            if (retire) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, ".cycles"}, m_cyc, e.cyc);
                    chk({e.name, ".instr_we"}, m_i, e.ni);
                    chk({e.name, ".pc_we"}, m_p, e.np);
                    chk({e.name, ".rf_we"}, m_r, e.nr);
                    chk({e.name, ".mem_we"}, m_m, e.nm);
                    chk({e.name, ".snap0"}, int'(hist[e.i0]),
                        int'(e.v0));
                    chk({e.name, ".snap1"}, int'(hist[e.i1]),
                        int'(e.v1));
                end
                m_cyc = 0; m_i = 0; m_p = 0; m_r = 0; m_m = 0;
            end else if (m_cyc > 40) begin
                chk("retire_timeout", m_cyc, 0);
                m_cyc = 0; m_i = 0; m_p = 0; m_r = 0; m_m = 0;
            end
        end
    end

    task automatic push(
        input string nm, input int cyc, input int ni, input int np,
        input int nr, input int nm_, input int i0,
        input logic [13:0] v0, input int i1, input logic [13:0] v1
    );
        exp_t e;
        e = '{nm, cyc, ni, np, nr, nm_, i0, v0, i1, v1};
        sb.push_back(e);
    endtask

    // Drive one instruction; pat[i] is mem_ready in cycle i.
    task automatic run(
        input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic z,
        input int n, input logic [0:15] pat
    );
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        alu_zero = z;
        for (int i = 0; i < n; i++) begin
            mem_ready = pat[i];
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [0:15] ALL = 16'hFFFF;
    localparam logic [13:0] SN_WB = 14'b0001_00_00_00_0000;
    localparam logic [13:0] SN_DEC = 14'b0000_01_01_00_0000;
    localparam logic [13:0] SN_FET = 14'b0010_00_10_10_0000;

    alu_vec_t tbl[10];

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'h00;
        alu_zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.instr_we", int'(instr_we), 0);
        chk("rst.pc_we", int'(pc_we), 0);
        chk("rst.retire", int'(retire), 0);
        chk("rst.halted", int'(halted), 0);
        chk("rst.illegal", int'(illegal), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        push("addi", 4, 1, 1, 1, 0,
             2, sn(0,0,0,0,2'b10,2'b01,2'b00,4'b0000), 3, SN_WB);
        run(7'b0010011, 3'b000, 7'h00, 1'b0, 4, ALL);

        push("beq", 3, 1, 2, 0, 0,
             1, SN_DEC, 2, sn(0,0,1,0,2'b10,2'b00,2'b00,4'b0001));
        run(7'b1100011, 3'b000, 7'h00, 1'b1, 3, ALL);

        push("bne", 3, 1, 1, 0, 0,
             1, SN_DEC, 2, sn(0,0,0,0,2'b10,2'b00,2'b00,4'b0001));
        run(7'b1100011, 3'b001, 7'h00, 1'b1, 3, ALL);

        push("bltu", 3, 1, 2, 0, 0,
             0, SN_FET, 2, sn(0,0,1,0,2'b10,2'b00,2'b00,4'b1001));
        run(7'b1100011, 3'b110, 7'h00, 1'b0, 3, ALL);

        push("bge", 3, 1, 2, 0, 0,
             1, SN_DEC, 2, sn(0,0,1,0,2'b10,2'b00,2'b00,4'b1000));
        run(7'b1100011, 3'b101, 7'h00, 1'b1, 3, ALL);

        push("lw", 10, 1, 1, 1, 0,
             5, sn(1,0,0,0,2'b00,2'b00,2'b00,4'b0000),
             9, sn(0,0,0,1,2'b00,2'b00,2'b01,4'b0000));
        run(7'b0000011, 3'b010, 7'h00, 1'b0, 10,
            16'b0011100011_000000);

        push("sw", 6, 1, 1, 0, 3,
             3, sn(1,1,0,0,2'b00,2'b00,2'b00,4'b0000),
             5, sn(1,1,0,0,2'b00,2'b00,2'b00,4'b0000));
        run(7'b0100011, 3'b010, 7'h00, 1'b0, 6,
            16'b111001_0000000000);

        push("jalr", 5, 1, 2, 1, 0,
             2, sn(0,0,0,0,2'b10,2'b01,2'b00,4'b0000),
             3, sn(0,0,1,0,2'b01,2'b10,2'b00,4'b0000));
        run(7'b1100111, 3'b000, 7'h00, 1'b0, 5, ALL);

        push("jal", 4, 1, 2, 1, 0,
             2, sn(0,0,1,0,2'b01,2'b10,2'b00,4'b0000), 3, SN_WB);
        run(7'b1101111, 3'b000, 7'h00, 1'b0, 4, ALL);

        push("lui", 4, 1, 1, 1, 0,
             2, sn(0,0,0,0,2'b11,2'b01,2'b00,4'b0000), 3, SN_WB);
        run(7'b0110111, 3'b000, 7'h00, 1'b0, 4, ALL);

        push("auipc", 4, 1, 1, 1, 0,
             2, sn(0,0,0,0,2'b01,2'b01,2'b00,4'b0000), 3, SN_WB);
        run(7'b0010111, 3'b000, 7'h00, 1'b0, 4, ALL);

        push("fence", 2, 1, 1, 0, 0, 0, SN_FET, 1, SN_DEC);
        run(7'b0001111, 3'b000, 7'h00, 1'b0, 2, ALL);

        tbl[0] = '{7'b0110011, 3'b000, 7'h20, 2'b00, 4'b0001};
        tbl[1] = '{7'b0010011, 3'b000, 7'h20, 2'b01, 4'b0000};
        tbl[2] = '{7'b0010011, 3'b101, 7'h20, 2'b01, 4'b0111};
        tbl[3] = '{7'b0110011, 3'b101, 7'h00, 2'b00, 4'b0110};
        tbl[4] = '{7'b0110011, 3'b011, 7'h00, 2'b00, 4'b1001};
        tbl[5] = '{7'b0110011, 3'b110, 7'h00, 2'b00, 4'b0011};
        tbl[6] = '{7'b0010011, 3'b100, 7'h00, 2'b01, 4'b0100};
        tbl[7] = '{7'b0010011, 3'b001, 7'h00, 2'b01, 4'b0101};
        tbl[8] = '{7'b0110011, 3'b111, 7'h00, 2'b00, 4'b0010};
        tbl[9] = '{7'b0010011, 3'b010, 7'h00, 2'b01, 4'b1000};
        for (int k = 0; k < 10; k++) begin
            push($sformatf("alu%0d", k), 4, 1, 1, 1, 0,
                 2, sn(0,0,0,0,2'b10,tbl[k].b,2'b00,tbl[k].aop),
                 3, SN_WB);
            run(tbl[k].op, tbl[k].f3, tbl[k].f7, 1'b0, 4, ALL);
        end

        // Directed: halt paths and reset mid-instruction.
        mon_en = 1'b0;
        run(7'b1110011, 3'b000, 7'h00, 1'b0, 2, ALL);
        @(negedge clk);
        chk("ecall.halted", int'(halted), 1);
        chk("ecall.illegal", int'(illegal), 0);
        chk("ecall.instr_we", int'(instr_we), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ecall.rst_halted", int'(halted), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(7'b0000000, 3'b000, 7'h00, 1'b0, 2, ALL);
        @(negedge clk);
        chk("illegal.halted", int'(halted), 1);
        chk("illegal.flag", int'(illegal), 1);
        chk("illegal.pc_we", int'(pc_we), 0);
        @(posedge clk); #1;
        chk("illegal.sticky", int'(illegal), 1);
        rst = 1'b1;
        #1;
        chk("illegal.rst_clear", int'(illegal), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(7'b0000011, 3'b010, 7'h00, 1'b0, 5,
            16'b11100_00000000000);
        mem_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort.rf_we", int'(rf_we), 0);
        chk("abort.retire", int'(retire), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        push("post_abort_addi", 4, 1, 1, 1, 0, 0, SN_FET, 3, SN_WB);
        run(7'b0010011, 3'b000, 7'h00, 1'b0, 4, ALL);

        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
